// File: rtl/flicky_rom_arb_pkg.sv
// Shared definitions for the Flicky program-ROM arbiter: FSM encoding,
// requester identifiers, sound-CPU ROM window and the opcode decrypt constants.
package flicky_rom_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ROMWAIT = 2'd1,
    ST_DECIDX  = 2'd2,
    ST_DECDATA = 2'd3
  } state_t;

  typedef enum logic {
    REQ_MAIN = 1'b0,
    REQ_SND  = 1'b1
  } req_t;

  localparam logic [2:0] SND_BASE_DEF = 3'b100;

  // Raw bits kept as-is, and the pattern XORed onto the table byte when raw bit 7 is set.
  localparam logic [7:0] DEC_AND_MASK = 8'h57;
  localparam logic [7:0] DEC_XOR_PAT  = 8'hA8;

  // Table index: four address taps, opcode/data select, then raw bits 5 and 3 folded with bit 7.
  function automatic logic [6:0] dec_index(input logic [7:0] raw,
                                           input logic [3:0] adr_sel,
                                           input logic       m1);
    logic f;
    f = raw[7];
    return {adr_sel, ~m1, raw[5] ^ f, raw[3] ^ f};
  endfunction

endpackage

// File: rtl/flicky_rom_dec.sv
// Combinational half of the main-CPU decryption: forms the decrypt-table index
// from the raw byte and fetch address, and mixes the table byte back into the raw one.
module flicky_rom_dec
  import flicky_rom_arb_pkg::*;
(
  input  logic [7:0] raw,
  input  logic [3:0] adr_sel,
  input  logic       m1,
  input  logic [7:0] dec_dt,
  output logic [6:0] dec_idx,
  output logic [7:0] mix_dt
);

  logic [7:0] xor_pat;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_xor_pat
      assign xor_pat[gi] = DEC_XOR_PAT[gi] & raw[7];
    end
  endgenerate

  assign dec_idx = dec_index(raw, adr_sel, m1);
  assign mix_dt  = (raw & DEC_AND_MASK) | (dec_dt ^ xor_pat);

endmodule

// File: rtl/flicky_rom_arb.sv
// Round-robin sharing of one program-ROM port between the main CPU (with
// two-step opcode/data decryption) and the sound CPU; each side sees a tagged, held byte.
module flicky_rom_arb
  import flicky_rom_arb_pkg::*;
#(
  parameter bit         DECRYPT  = 1'b1,
  parameter logic [2:0] SND_BASE = SND_BASE_DEF
) (
  input  logic        CLK48M,
  input  logic        RESET,
  input  logic        M_RD,
  input  logic        M_M1,
  input  logic [14:0] M_ADR,
  output logic [7:0]  M_DT,
  output logic        M_RDY,
  input  logic        S_RD,
  input  logic [12:0] S_ADR,
  output logic [7:0]  S_DT,
  output logic        S_RDY,
  output logic        ROM_REQ,
  output logic [15:0] ROM_ADR,
  input  logic        ROM_ACK,
  input  logic [7:0]  ROM_DT,
  output logic [6:0]  DEC_IDX,
  input  logic [7:0]  DEC_DT
);

  state_t      state_reg;
  req_t        last_reg;
  req_t        grant_reg;
  logic [14:0] fetch_adr_reg;
  logic        fetch_m1_reg;
  logic [7:0]  raw_reg;
  logic        rom_req_reg;
  logic [15:0] rom_adr_reg;
  logic [6:0]  dec_idx_reg;
  logic [7:0]  m_dt_reg;
  logic [7:0]  s_dt_reg;
  logic        m_tag_valid_reg;
  logic        m_tag_m1_reg;
  logic [14:0] m_tag_adr_reg;
  logic        s_tag_valid_reg;
  logic [12:0] s_tag_adr_reg;

  logic        m_rdy;
  logic        s_rdy;
  logic        m_pend;
  logic        s_pend;
  logic        grant_snd;
  logic [3:0]  adr_sel;
  logic [7:0]  dec_raw;
  logic [6:0]  dec_idx_next;
  logic [7:0]  mix_dt;

  // A byte is only "ready" while the CPU still asks for exactly what was fetched.
  assign m_rdy  = m_tag_valid_reg && (m_tag_m1_reg == M_M1) && (m_tag_adr_reg == M_ADR);
  assign s_rdy  = s_tag_valid_reg && (s_tag_adr_reg == S_ADR);
  assign m_pend = M_RD && !m_rdy;
  assign s_pend = S_RD && !s_rdy;

  // Sound wins only when main is idle or main was the one served last.
  assign grant_snd = s_pend && (!m_pend || (last_reg == REQ_MAIN));

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_adr_sel
      assign adr_sel[gi] = fetch_adr_reg[4 * gi];
    end
  endgenerate

  // The index is formed from the live ROM byte at ACK; the mix uses the captured copy.
  assign dec_raw = (state_reg == ST_ROMWAIT) ? ROM_DT : raw_reg;

  flicky_rom_dec u_dec (
    .raw     (dec_raw),
    .adr_sel (adr_sel),
    .m1      (fetch_m1_reg),
    .dec_dt  (DEC_DT),
    .dec_idx (dec_idx_next),
    .mix_dt  (mix_dt)
  );

  always_ff @(posedge CLK48M) begin
    if (RESET) begin
      state_reg       <= ST_IDLE;
      last_reg        <= REQ_SND;
      grant_reg       <= REQ_MAIN;
      fetch_adr_reg   <= '0;
      fetch_m1_reg    <= 1'b0;
      raw_reg         <= '0;
      rom_req_reg     <= 1'b0;
      rom_adr_reg     <= '0;
      dec_idx_reg     <= '0;
      m_dt_reg        <= '0;
      s_dt_reg        <= '0;
      m_tag_valid_reg <= 1'b0;
      m_tag_m1_reg    <= 1'b0;
      m_tag_adr_reg   <= '0;
      s_tag_valid_reg <= 1'b0;
      s_tag_adr_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (m_pend || s_pend) begin
            rom_req_reg <= 1'b1;
            state_reg   <= ST_ROMWAIT;
            if (grant_snd) begin
              grant_reg     <= REQ_SND;
              last_reg      <= REQ_SND;
              fetch_adr_reg <= {2'b00, S_ADR};
              fetch_m1_reg  <= 1'b0;
              rom_adr_reg   <= {SND_BASE, S_ADR};
            end else begin
              grant_reg     <= REQ_MAIN;
              last_reg      <= REQ_MAIN;
              fetch_adr_reg <= M_ADR;
              fetch_m1_reg  <= M_M1;
              rom_adr_reg   <= {1'b0, M_ADR};
            end
          end
        end

        ST_ROMWAIT: begin
          if (ROM_ACK) begin
            rom_req_reg <= 1'b0;
            if (grant_reg == REQ_SND) begin
              s_dt_reg        <= ROM_DT;
              s_tag_valid_reg <= 1'b1;
              s_tag_adr_reg   <= fetch_adr_reg[12:0];
              state_reg       <= ST_IDLE;
            end else if (!DECRYPT) begin
              m_dt_reg        <= ROM_DT;
              m_tag_valid_reg <= 1'b1;
              m_tag_m1_reg    <= fetch_m1_reg;
              m_tag_adr_reg   <= fetch_adr_reg;
              state_reg       <= ST_IDLE;
            end else begin
              // Registering the index here gives the table its one read cycle in DECIDX.
              raw_reg     <= ROM_DT;
              dec_idx_reg <= dec_idx_next;
              state_reg   <= ST_DECIDX;
            end
          end
        end

        ST_DECIDX: begin
          state_reg <= ST_DECDATA;
        end

        ST_DECDATA: begin
          m_dt_reg        <= mix_dt;
          m_tag_valid_reg <= 1'b1;
          m_tag_m1_reg    <= fetch_m1_reg;
          m_tag_adr_reg   <= fetch_adr_reg;
          state_reg       <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign M_DT    = m_dt_reg;
  assign M_RDY   = m_rdy;
  assign S_DT    = s_dt_reg;
  assign S_RDY   = s_rdy;
  assign ROM_REQ = rom_req_reg;
  assign ROM_ADR = rom_adr_reg;
  assign DEC_IDX = dec_idx_reg;

endmodule

// File: tb/tb_flicky_rom_arb.sv
// Bench for flicky_rom_arb: ROM responder with variable wait, synchronous decrypt
// table, table-driven decrypt vectors, directed corner sequences and random traffic.
module tb_flicky_rom_arb;

  logic        CLK48M;
  logic        RESET;
  logic        M_RD;
  logic        M_M1;
  logic [14:0] M_ADR;
  logic [7:0]  M_DT;
  logic        M_RDY;
  logic        S_RD;
  logic [12:0] S_ADR;
  logic [7:0]  S_DT;
  logic        S_RDY;
  logic        ROM_REQ;
  logic [15:0] ROM_ADR;
  logic        ROM_ACK;
  logic [7:0]  ROM_DT;
  logic [6:0]  DEC_IDX;
  logic [7:0]  DEC_DT;

  flicky_rom_arb dut (
    .CLK48M  (CLK48M),
    .RESET   (RESET),
    .M_RD    (M_RD),
    .M_M1    (M_M1),
    .M_ADR   (M_ADR),
    .M_DT    (M_DT),
    .M_RDY   (M_RDY),
    .S_RD    (S_RD),
    .S_ADR   (S_ADR),
    .S_DT    (S_DT),
    .S_RDY   (S_RDY),
    .ROM_REQ (ROM_REQ),
    .ROM_ADR (ROM_ADR),
    .ROM_ACK (ROM_ACK),
    .ROM_DT  (ROM_DT),
    .DEC_IDX (DEC_IDX),
    .DEC_DT  (DEC_DT)
  );

  initial begin
    CLK48M = 1'b0;
    forever #5 CLK48M = ~CLK48M;
  end

  int          total;
  int          bad;
  int          cyc;
  int          last_ack_cyc;
  logic [7:0]  dec_tab [128];
  int          fixed_wait;
  bit          resp_enable;
  bit          force_raw_en;
  logic [7:0]  force_raw;
  int          force_ack_at;
  logic [15:0] grant_adr [256];
  int          grant_cnt;

  // Cycle counter, ACK timestamp and the 1-cycle-latency decrypt table.
  always @(posedge CLK48M) begin
    cyc <= cyc + 1;
    if (ROM_ACK) last_ack_cyc <= cyc + 1;
    DEC_DT <= dec_tab[DEC_IDX];
  end

  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    return a[7:0] ^ {a[14:8], a[15]} ^ 8'h5C;
  endfunction

  function automatic logic [7:0] exp_main(input logic [14:0] a, input logic m1);
    logic [7:0] r;
    logic       f;
    logic [6:0] idx;
    r   = rom_byte({1'b0, a});
    f   = r[7];
    idx = {a[12], a[8], a[4], a[0], ~m1, r[5] ^ f, r[3] ^ f};
    return (r & 8'h57) | (dec_tab[idx] ^ (f ? 8'hA8 : 8'h00));
  endfunction

  function automatic logic [7:0] exp_snd(input logic [12:0] a);
    return rom_byte({3'b100, a});
  endfunction

  // ROM model: answers a held request after 0..3 wait cycles and logs each grant.
  initial begin : responder
    int wait_left;
    wait_left = -1;
    ROM_ACK   = 1'b0;
    ROM_DT    = 8'h00;
    forever begin
      @(negedge CLK48M);
      ROM_ACK = 1'b0;
      if (cyc == force_ack_at) begin
        ROM_ACK = 1'b1;
        ROM_DT  = 8'h77;
      end else if (ROM_REQ && resp_enable) begin
        if (wait_left < 0)
          wait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
        if (wait_left == 0) begin
          ROM_ACK = 1'b1;
          ROM_DT  = force_raw_en ? force_raw : rom_byte(ROM_ADR);
          grant_adr[grant_cnt[7:0]] = ROM_ADR;
          grant_cnt = grant_cnt + 1;
          wait_left = -1;
        end else begin
          wait_left = wait_left - 1;
        end
      end else begin
        wait_left = -1;
      end
    end
  end

  task automatic tick();
    @(negedge CLK48M);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_rdy(input bit snd, input string name, output int at_cyc);
    int n;
    n      = 0;
    at_cyc = -1;
    #1;
    while (((snd ? S_RDY : M_RDY) !== 1'b1) && (n < 80)) begin
      tick();
      n = n + 1;
    end
    if ((snd ? S_RDY : M_RDY) !== 1'b1) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL %s: RDY got 0 after %0d cycles, expected 1", name, n);
    end else begin
      at_cyc = cyc;
    end
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (ROM_REQ !== 1'b1 && n < 40) begin
      tick();
      n = n + 1;
    end
    if (ROM_REQ !== 1'b1) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL %s: ROM_REQ got 0, expected 1", name);
    end
  endtask

  typedef struct {
    logic        m1;
    logic [14:0] adr;
    logic [7:0]  raw;
    logic [6:0]  idx;
    logic [7:0]  dt;
  } vec_t;

  initial begin : main
    vec_t vecs [4];
    int   at;
    int   n;
    int   g0;
    int   mode;
    bit   saw_rdy;

    total = 0; bad = 0;
    M_RD = 1'b0; M_M1 = 1'b0; M_ADR = '0; S_RD = 1'b0; S_ADR = '0; RESET = 1'b1;
    fixed_wait = -1; resp_enable = 1'b1; force_raw_en = 1'b0; force_raw = 8'h00; force_ack_at = -1;
    for (int i = 0; i < 128; i++) dec_tab[i] = 8'(i * 37 + 11);
    dec_tab[7'h00] = 8'h20;
    dec_tab[7'h03] = 8'h08;
    dec_tab[7'h7C] = 8'h5A;
    dec_tab[7'h1B] = 8'h90;

    // {m1, adr, raw, DEC_IDX, M_DT}
    vecs[0] = '{1'b1, 15'h0000, 8'h00, 7'h00,        8'h20};
    vecs[1] = '{1'b1, 15'h0002, 8'h80, 7'h03,        8'hA0};
    vecs[2] = '{1'b0, 15'h1111, 8'h00, 7'b1111_1_00, 8'h5A};
    vecs[3] = '{1'b1, 15'h0011, 8'h2C, 7'h1B,        8'h94};

    repeat (3) tick();
    check("rst_rom_req", 32'(ROM_REQ), 32'd0);
    check("rst_rom_adr", 32'(ROM_ADR), 32'd0);
    check("rst_dec_idx", 32'(DEC_IDX), 32'd0);
    check("rst_dt",      32'({M_DT, S_DT}), 32'd0);
    check("rst_rdy",     32'({M_RDY, S_RDY}), 32'd0);
    RESET = 1'b0;
    tick();

    fixed_wait   = 1;
    force_raw_en = 1'b1;
    for (int v = 0; v < 4; v++) begin
      force_raw = vecs[v].raw;
      M_M1  = vecs[v].m1;
      M_ADR = vecs[v].adr;
      M_RD  = 1'b1;
      wait_rdy(1'b0, "vec_rdy", at);
      if (at >= 0) begin
        check("vec_dec_idx", 32'(DEC_IDX), 32'(vecs[v].idx));
        check("vec_m_dt",    32'(M_DT),    32'(vecs[v].dt));
        check("vec_latency", 32'(at - last_ack_cyc + 1), 32'd3);
      end
      $display("vec %0d m1=%0d adr=%h raw=%h idx=%h dt=%h", v, vecs[v].m1, vecs[v].adr,
               vecs[v].raw, DEC_IDX, M_DT);
    end
    M_RD = 1'b0;
    force_raw_en = 1'b0;
    tick();

    S_ADR = 13'h0ABC;
    S_RD  = 1'b1;
    wait_rdy(1'b1, "snd_rdy", at);
    if (at >= 0) begin
      check("snd_dt",      32'(S_DT), 32'(exp_snd(13'h0ABC)));
      check("snd_latency", 32'(at - last_ack_cyc + 1), 32'd1);
      check("snd_rom_adr", 32'(ROM_ADR), 32'h8ABC);
    end
    $display("snd adr=%h dt=%h", S_ADR, S_DT);
    S_RD = 1'b0;
    tick();

    // Both requesters pending out of reset, kept pending by moving each address once served.
    RESET = 1'b1; fixed_wait = -1;
    M_M1 = 1'b1; M_ADR = 15'h0040; M_RD = 1'b1;
    S_ADR = 13'h0123; S_RD = 1'b1;
    tick(); tick();
    g0 = grant_cnt;
    RESET = 1'b0;
    n = 0;
    while (grant_cnt < g0 + 8 && n < 400) begin
      tick();
      n = n + 1;
      if (M_RDY) begin
        check("fair_m_dt", 32'(M_DT), 32'(exp_main(M_ADR, M_M1)));
        M_ADR = M_ADR + 15'd1;
      end
      if (S_RDY) begin
        check("fair_s_dt", 32'(S_DT), 32'(exp_snd(S_ADR)));
        S_ADR = S_ADR + 13'd1;
      end
    end
    check("fair_grants", 32'(grant_cnt >= g0 + 8), 32'd1);
    check("fair_second_adr", 32'(grant_adr[8'(g0 + 1)]), 32'h8123);
    for (int k = 0; k < 8; k++) begin
      check("fair_alternate", 32'(grant_adr[8'(g0 + k)][15]), 32'(k % 2));
      $display("grant %0d rom_adr=%h", k, grant_adr[8'(g0 + k)]);
    end
    M_RD = 1'b0; S_RD = 1'b0;
    repeat (20) tick();

    // Address moves while the ROM is still answering the first fetch.
    fixed_wait = 3;
    M_M1 = 1'b0; M_ADR = 15'h2345; M_RD = 1'b1;
    g0 = grant_cnt;
    wait_req("chg_req");
    tick();
    M_ADR = 15'h2346;
    saw_rdy = 1'b0;
    n = 0;
    while (grant_cnt < g0 + 2 && n < 100) begin
      tick();
      n = n + 1;
      if (M_RDY) saw_rdy = 1'b1;
    end
    check("chg_rdy_low",    32'(saw_rdy), 32'd0);
    check("chg_first_adr",  32'(grant_adr[8'(g0)]),     32'h2345);
    check("chg_second_adr", 32'(grant_adr[8'(g0 + 1)]), 32'h2346);
    wait_rdy(1'b0, "chg_rdy", at);
    if (at >= 0) check("chg_m_dt", 32'(M_DT), 32'(exp_main(15'h2346, 1'b0)));
    $display("addr change adr=%h dt=%h", M_ADR, M_DT);
    M_RD = 1'b0;
    fixed_wait = -1;
    tick();

    for (int t = 0; t < 30; t++) begin
      mode  = int'($urandom_range(0, 2));
      M_ADR = 15'($urandom);
      M_M1  = 1'($urandom);
      S_ADR = 13'($urandom);
      M_RD  = (mode != 1);
      S_RD  = (mode != 0);
      if (M_RD) begin
        wait_rdy(1'b0, "rand_m_rdy", at);
        if (at >= 0) check("rand_m_dt", 32'(M_DT), 32'(exp_main(M_ADR, M_M1)));
      end
      if (S_RD) begin
        wait_rdy(1'b1, "rand_s_rdy", at);
        if (at >= 0) check("rand_s_dt", 32'(S_DT), 32'(exp_snd(S_ADR)));
      end
      $display("rand %0d mode=%0d m_adr=%h m1=%0d m_dt=%h s_adr=%h s_dt=%h",
               t, mode, M_ADR, M_M1, M_DT, S_ADR, S_DT);
      M_RD = 1'b0; S_RD = 1'b0;
      tick();
    end

    // Reset while the ROM is slow to answer; the late ACK must be ignored.
    resp_enable = 1'b0;
    M_M1 = 1'b1; M_ADR = 15'h0777; M_RD = 1'b1;
    wait_req("rst_mid_req");
    tick(); tick();
    RESET = 1'b1; M_RD = 1'b0; S_RD = 1'b0;
    tick();
    check("rst_mid_rom_req", 32'(ROM_REQ), 32'd0);
    check("rst_mid_rdy",     32'({M_RDY, S_RDY}), 32'd0);
    RESET = 1'b0;
    force_ack_at = cyc + 1;
    repeat (4) tick();
    check("late_ack_dt",      32'({M_DT, S_DT}), 32'd0);
    check("late_ack_rdy",     32'({M_RDY, S_RDY}), 32'd0);
    check("late_ack_rom_req", 32'(ROM_REQ), 32'd0);
    $display("reset mid-fetch m_dt=%h s_dt=%h", M_DT, S_DT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flicky_rom_arb.md
# flicky_rom_arb

Time-multiplexes one shared program-ROM port between the main CPU (encrypted opcode/data space) and the sound CPU. Fetches run on CLK48M, and each CPU sees a held byte plus a ready flag. For main-CPU fetches the block also sequences the two-step decryption: raw byte first, then the decrypt-table lookup. It sits between both CPU cores and the external ROM/SDRAM loader port, and it replaces the fixed two-phase ROM access.

## Interface
Parameters:
- DECRYPT, 1, when 0 main-CPU bytes bypass the table and M_DT is the raw byte.
- SND_BASE, 3'b100, ROM_ADR[15:13] prefix applied to sound-CPU fetches.

Ports:
- CLK48M  in  1  sole clock, rising edge.
- RESET  in  1  synchronous, active-high.
- M_RD  in  1  main CPU requests a ROM byte (level).
- M_M1  in  1  main CPU opcode fetch.
- M_ADR  in  15  main CPU address.
- M_DT  out  8  main byte, decrypted.
- M_RDY  out  1  M_DT valid for the current {M_M1,M_ADR}.
- S_RD  in  1  sound CPU request (level).
- S_ADR  in  13  sound CPU address.
- S_DT  out  8  sound byte.
- S_RDY  out  1  S_DT valid for the current S_ADR.
- ROM_REQ  out  1  shared ROM request (level).
- ROM_ADR  out  16  shared ROM byte address.
- ROM_ACK  in  1  one-cycle pulse; ROM_DT is valid in the same cycle.
- ROM_DT  in  8  ROM data.
- DEC_IDX  out  7  decrypt-table address, synchronous ROM with 1-cycle read latency.
- DEC_DT  in  8  decrypt-table data.

## Operation
- Each requester has a tag register: main {valid, m1, adr[14:0]}, sound {valid, adr[12:0]}. Each also has a data register (M_DT, S_DT).
- M_RDY = tag valid & tag == {M_M1,M_ADR}, combinational compare.
- S_RDY is formed the same way from the sound tag and S_ADR.
- A requester is pending when its RD is high and its RDY is low.
- State machine states: IDLE, ROMWAIT, DECIDX, DECDATA.
- IDLE, with one or more requesters pending:
  - grant by round-robin; `last` is the requester served most recently, and main wins on a tie after reset;
  - latch the requester's address/m1 into the fetch registers;
  - assert ROM_REQ the next cycle and go to ROMWAIT.
- Fetch address on ROM_ADR:
  - main: {1'b0, adr};
  - sound: {SND_BASE, adr}.
- ROMWAIT: ROM_REQ and ROM_ADR are held constant until ROM_ACK.
- ROMWAIT, on ROM_ACK:
  - ROM_REQ drops the same edge;
  - sound grant: write S_DT and the sound tag, go to IDLE;
  - main grant with DECRYPT=0: write M_DT and the main tag, go to IDLE;
  - main grant with DECRYPT=1: capture the raw byte r and go to DECIDX.
- DECIDX:
  - DEC_IDX = {a12, a8, a4, a0, ~m1, r5^f, r3^f}, where f = r7;
  - go to DECDATA.
- DECDATA:
  - M_DT = (r & 8'h57) | (DEC_DT ^ {f,0,f,0,f,000});
  - write the main tag, go to IDLE.
- Address change during a fetch: the fetch completes and the tag takes the latched address. RDY then stays low because of the mismatch, and a new fetch is arbitrated from IDLE.
- ROM_ACK outside ROMWAIT is ignored.

## Timing
- Reset values:
  - ROM_REQ=0, ROM_ADR=0, DEC_IDX=0, M_DT=S_DT=8'h00;
  - both tags invalid, so M_RDY=S_RDY=0;
  - state IDLE, `last`=sound.
- RESET mid-fetch: ROM_REQ is 0 at the first edge with RESET high. A late ACK is dropped.
- Latency from the pending condition to RDY, excluding ROM wait: 1 cycle to REQ, then 0 or more ROM wait cycles, then ACK.
  - Sound: RDY is high 1 cycle after ACK.
  - Main with DECRYPT=1: RDY is high 3 cycles after ACK (DECIDX, DECDATA, write).
- Back-to-back: after the data write, IDLE may grant in the next cycle, giving at least 1 idle cycle between ROM_REQ pulses.
- Fairness: with both requesters continuously pending, grants strictly alternate.

## Structure
- Shared package holds:
  - state encoding constants;
  - SND_BASE default;
  - decrypt constants: AND mask 8'h57 and XOR pattern 8'hA8.
- One sub-module, flicky_rom_dec: combinational DEC_IDX formation and the final mix from r, fetch address, m1 and DEC_DT. The FSM stays in the top module.

## Test plan
- Main only, DECRYPT=1, M_ADR=0, M_M1=1, ROM byte 8'h00, DEC_DT model returns 8'h20 at idx 0:
  - DEC_IDX=7'h00;
  - M_DT=8'h20;
  - M_RDY rises 3 cycles after ACK.
- Main, raw byte 8'h80, M_M1=1, table idx 7'h03 → 8'h08:
  - DEC_IDX=7'h03;
  - M_DT=8'hA0.
- Main, M_M1=0, M_ADR=15'h1111, raw 8'h00:
  - DEC_IDX=7'b1111_1_00.
- Sound S_ADR=13'h0123 and main both pending from reset:
  - main granted first;
  - ROM_ADR=16'h8123 on the second grant;
  - grants alternate across 8 fetches.
- Address change: M_ADR changes mid-ROMWAIT:
  - M_RDY stays 0;
  - a second fetch with the new address follows.
- RESET asserted in ROMWAIT, then ACK 2 cycles later:
  - ROM_REQ=0, both RDY=0;
  - the ACK produces no data write.
